// File: rtl/timer_responder_pkg.sv
// rtl/timer_responder_pkg.sv - shared register offsets, CTRL fields, modes and FSM states
package timer_responder_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_PSC    = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_responder_tc_prescaler.sv
// rtl/timer_responder_tc_prescaler.sv - prescale counter emitting one tick per PSC+1 running cycles
module tc_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_run,
  input  logic [15:0] i_psc,
  output logic        o_tick
);

  logic [15:0] r_cnt;

  assign o_tick = i_run && (r_cnt == i_psc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= o_tick ? 16'd0 : r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/timer_responder.sv
// rtl/timer_responder.sv - memory-mapped countdown timer responder with maskable irq
// Optional prescaler at offset 0xC enabled by defining TIMER_PRESCALE_EN.
module timer_responder
  import timer_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic        hit,
  output logic [31:0] rd,
  output logic        irq
);

  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_flag;
  state_t      r_state;

  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_tick;
  logic [1:0]  w_mode;
  logic        w_unused;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = addr[3:2];
  assign w_wr      = hit && we;
  assign w_ctrl_wr = w_wr && (w_off == OFF_CTRL);
  assign w_mode    = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign irq       = r_flag && r_ctrl[CTRL_IM];
  assign w_unused  = &{1'b0, addr[1:0]};

`ifdef TIMER_PRESCALE_EN
  logic [15:0] r_psc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psc <= '0;
    end else if (w_wr && (w_off == OFF_PSC)) begin
      r_psc <= wd[15:0];
    end
  end

  tc_prescaler u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == ST_LOAD),
    .i_run   (r_state == ST_CNT),
    .i_psc   (r_psc),
    .o_tick  (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_comb begin
    rd = '0;
    if (hit) begin
      case (w_off)
        OFF_CTRL:   rd = {28'd0, r_ctrl};
        OFF_PRESET: rd = r_preset;
        OFF_COUNT:  rd = r_count;
`ifdef TIMER_PRESCALE_EN
        OFF_PSC:    rd = {16'd0, r_psc};
`endif
        default:    rd = '0;
      endcase
    end
  end

  // The CTRL write sits after the FSM case so a bus write overrides the FSM's EN clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl   <= '0;
      r_preset <= '0;
      r_count  <= '0;
      r_flag   <= 1'b0;
      r_state  <= ST_IDLE;
    end else begin
      if (w_wr && (w_off == OFF_PRESET)) begin
        r_preset <= wd;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_ctrl[CTRL_EN]) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_ctrl[CTRL_EN]) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            if (r_count != 32'd0) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_state <= ST_INT;
              r_flag  <= 1'b1;
            end
          end
        end
        ST_INT: begin
          if (w_mode == MODE_RELOAD) begin
            r_flag  <= 1'b0;
            r_state <= ST_LOAD;
          end else begin
            r_ctrl[CTRL_EN] <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_ctrl_wr) begin
        r_ctrl <= wd[3:0];
        r_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_responder.sv
// tb/tb_timer_responder.sv - directed scoreboard bench for timer_responder
module tb_timer_responder;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic        hit;
  logic [31:0] rd;
  logic        irq;

  int n_tests;
  int n_fail;
  logic [31:0] sb[$];

  timer_responder #(.BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .hit  (hit),
    .rd   (rd),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
    addr = 32'd0;
    wd   = 32'd0;
  endtask

  task automatic read_exp(input logic [31:0] a, input logic [31:0] exp, input string tag);
    sb.push_back(exp);
    addr = a;
    #1;
    chk(tag, rd);
    addr = 32'd0;
  endtask

  task automatic irq_exp(input logic exp, input string tag);
    sb.push_back({31'd0, exp});
    chk(tag, {31'd0, irq});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b0;
    addr = 32'd0;
    we   = 1'b0;
    wd   = 32'd0;
    edges(2);
    read_exp(BASE + 32'h0, 32'd0, "rst_ctrl");
    read_exp(BASE + 32'h4, 32'd0, "rst_preset");
    read_exp(BASE + 32'h8, 32'd0, "rst_count");
    irq_exp(1'b0, "rst_irq");
    rst = 1'b1;
    edges(1);

    // one-shot, PRESET=3, IM set
    bus_write(BASE + 32'h4, 32'd3);
    bus_write(BASE + 32'h0, 32'h9);
    edges(2);
    read_exp(BASE + 32'h8, 32'd3, "os_count_e2");
    edges(1);
    read_exp(BASE + 32'h8, 32'd2, "os_count_e3");
    edges(1);
    read_exp(BASE + 32'h8, 32'd1, "os_count_e4");
    edges(1);
    read_exp(BASE + 32'h8, 32'd0, "os_count_e5");
    irq_exp(1'b0, "os_irq_e5");
    edges(1);
    irq_exp(1'b1, "os_irq_e6");
    edges(1);
    read_exp(BASE + 32'h0, 32'h8, "os_ctrl_e7");
    irq_exp(1'b1, "os_irq_e7");
    edges(3);
    irq_exp(1'b1, "os_irq_hold");
    read_exp(BASE + 32'h8, 32'd0, "os_count_stop");
    bus_write(BASE + 32'h0, 32'h8);
    irq_exp(1'b0, "os_irq_clr");

    // writes that must not land
    bus_write(BASE + 32'h8, 32'd7);
    read_exp(BASE + 32'h8, 32'd0, "count_ro");
    sb.push_back(32'd0);
    addr = BASE + 32'h10;
    #1;
    chk("miss_hit", {31'd0, hit});
    bus_write(BASE + 32'h10, 32'h55);
    read_exp(BASE + 32'h10, 32'd0, "miss_rd");
    read_exp(BASE + 32'h0, 32'h8, "miss_ctrl");
    read_exp(BASE + 32'h4, 32'd3, "miss_preset");

    // PRESET=0 one-shot; bus write of EN=1 on the INT edge wins and restarts
    bus_write(BASE + 32'h4, 32'd0);
    bus_write(BASE + 32'h0, 32'h9);
    edges(3);
    irq_exp(1'b1, "p0_irq_e3");
    bus_write(BASE + 32'h0, 32'h9);
    read_exp(BASE + 32'h0, 32'h9, "win_ctrl_e4");
    irq_exp(1'b0, "win_irq_e4");
    edges(3);
    irq_exp(1'b1, "win_irq_e7");
    edges(1);
    read_exp(BASE + 32'h0, 32'h8, "win_ctrl_e8");

    // masked one-shot
    bus_write(BASE + 32'h0, 32'h1);
    edges(3);
    irq_exp(1'b0, "im0_irq_e3");
    edges(2);
    read_exp(BASE + 32'h0, 32'h0, "im0_ctrl");
    irq_exp(1'b0, "im0_irq_e5");
    bus_write(BASE + 32'h0, 32'h8);
    irq_exp(1'b0, "im0_irq_clr");

    // auto-reload, PRESET=2: pulse on edges 5 and 10
    bus_write(BASE + 32'h4, 32'd2);
    bus_write(BASE + 32'h0, 32'hB);
    for (int e = 1; e <= 11; e++) begin
      edges(1);
      irq_exp((e == 5) || (e == 10), $sformatf("ar_irq_e%0d", e));
      if (e == 7) read_exp(BASE + 32'h8, 32'd2, "ar_reload");
    end
    bus_write(BASE + 32'h0, 32'h0);
    edges(4);
    read_exp(BASE + 32'h8, 32'd2, "ar_stop_count");
    irq_exp(1'b0, "ar_stop_irq");

    bus_write(BASE + 32'hC, 32'd5);
`ifdef TIMER_PRESCALE_EN
    read_exp(BASE + 32'hC, 32'd5, "psc_rd");
    bus_write(BASE + 32'hC, 32'd0);
`else
    read_exp(BASE + 32'hC, 32'd0, "psc_rd");
`endif

    // asynchronous reset mid-count
    bus_write(BASE + 32'h4, 32'd10);
    bus_write(BASE + 32'h0, 32'h9);
    edges(7);
    read_exp(BASE + 32'h8, 32'd5, "mid_count");
    #2;
    rst = 1'b0;
    #1;
    read_exp(BASE + 32'h8, 32'd0, "ar_rst_count");
    read_exp(BASE + 32'h0, 32'd0, "ar_rst_ctrl");
    read_exp(BASE + 32'h4, 32'd0, "ar_rst_preset");
    irq_exp(1'b0, "ar_rst_irq");
    edges(2);
    rst = 1'b1;
    edges(3);
    read_exp(BASE + 32'h8, 32'd0, "post_rst_count");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
